// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings, states and constants for the RV32M divide sequencer
package div_pkg;

  // funct3[1:0] encodings of the divide/remainder family
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  // Sequencer states
  typedef logic [1:0] div_state_t;
  localparam div_state_t ST_IDLE  = 2'd0;
  localparam div_state_t ST_RUN   = 2'd1;
  localparam div_state_t ST_DRAIN = 2'd2;
  localparam div_state_t ST_DONE  = 2'd3;

  // RISC-V defined results for divide-by-zero and signed overflow
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // Two's-complement negate when neg is set, pass through otherwise
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_special_case.sv
// rtl/div_special_case.sv - combinational detection of divide-by-zero and signed overflow
module div_special_case
  import div_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        is_signed,
  output logic        is_special,
  output logic [31:0] special_q,
  output logic [31:0] special_r
);

  // Divide-by-zero takes priority; overflow only exists for signed ops
  always_comb begin
    is_special = 1'b0;
    special_q  = 32'd0;
    special_r  = 32'd0;
    if (rs2 == 32'd0) begin
      is_special = 1'b1;
      special_q  = DIV_ZERO_Q;
      special_r  = rs1;
    end else if (is_signed && (rs1 == INT_MIN) && (rs2 == 32'hFFFF_FFFF)) begin
      is_special = 1'b1;
      special_q  = INT_MIN;
      special_r  = 32'd0;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - request sequencing, sign handling and result cache around the divider core
module div_sequencer
  import div_pkg::*;
#(
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             core_start,
  output logic [31:0]      core_dividend,
  output logic [31:0]      core_divisor,
  input  logic             core_done,
  input  logic [31:0]      core_quotient,
  input  logic [31:0]      core_remainder
);

  div_state_t       state;

  // Operation in flight on the core
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic [31:0]      pend_rs1;
  logic [31:0]      pend_rs2;
  logic             pend_signed;

  // One-entry cache of the last core-computed pair
  logic             cache_valid;
  logic [31:0]      cache_rs1;
  logic [31:0]      cache_rs2;
  logic             cache_signed;
  logic [31:0]      cache_quot;
  logic [31:0]      cache_rem;

  logic             req_signed;
  logic             accept;
  logic             cache_hit;
  logic [31:0]      mag_rs1;
  logic [31:0]      mag_rs2;
  logic             is_special;
  logic [31:0]      special_q;
  logic [31:0]      special_r;
  logic [31:0]      corr_q;
  logic [31:0]      corr_r;

  assign req_ready  = (state == ST_IDLE) && !flush && !rst;
  assign accept     = req_valid && req_ready;
  assign req_signed = ~req_op[0];
  assign mag_rs1    = neg_if(req_rs1, req_signed & req_rs1[31]);
  assign mag_rs2    = neg_if(req_rs2, req_signed & req_rs2[31]);
  assign cache_hit  = CACHE_EN && cache_valid && (cache_rs1 == req_rs1) &&
                      (cache_rs2 == req_rs2) && (cache_signed == req_signed);
  assign corr_q     = neg_if(core_quotient, neg_q_q);
  assign corr_r     = neg_if(core_remainder, neg_r_q);

  div_special_case u_special (
    .rs1        (req_rs1),
    .rs2        (req_rs2),
    .is_signed  (req_signed),
    .is_special (is_special),
    .special_q  (special_q),
    .special_r  (special_r)
  );

  // Main control: accept, dispatch to core, complete, drain after flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      resp_valid    <= 1'b0;
      resp_data     <= 32'd0;
      resp_tag      <= '0;
      core_start    <= 1'b0;
      core_dividend <= 32'd0;
      core_divisor  <= 32'd0;
      cache_valid   <= 1'b0;
      cache_rs1     <= 32'd0;
      cache_rs2     <= 32'd0;
      cache_signed  <= 1'b0;
      cache_quot    <= 32'd0;
      cache_rem     <= 32'd0;
      op_q          <= 2'd0;
      tag_q         <= '0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      pend_rs1      <= 32'd0;
      pend_rs2      <= 32'd0;
      pend_signed   <= 1'b0;
    end else begin
      core_start <= 1'b0;
      if (flush) begin
        cache_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_special) begin
              resp_data  <= req_op[1] ? special_r : special_q;
              resp_tag   <= req_tag;
              resp_valid <= 1'b1;
              state      <= ST_DONE;
            end else if (cache_hit) begin
              resp_data  <= req_op[1] ? cache_rem : cache_quot;
              resp_tag   <= req_tag;
              resp_valid <= 1'b1;
              state      <= ST_DONE;
            end else begin
              op_q          <= req_op;
              tag_q         <= req_tag;
              neg_q_q       <= req_signed & (req_rs1[31] ^ req_rs2[31]);
              neg_r_q       <= req_signed & req_rs1[31];
              pend_rs1      <= req_rs1;
              pend_rs2      <= req_rs2;
              pend_signed   <= req_signed;
              core_dividend <= mag_rs1;
              core_divisor  <= mag_rs2;
              core_start    <= 1'b1;
              state         <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (core_done) begin
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              resp_data    <= op_q[1] ? corr_r : corr_q;
              resp_tag     <= tag_q;
              resp_valid   <= 1'b1;
              cache_valid  <= 1'b1;
              cache_rs1    <= pend_rs1;
              cache_rs2    <= pend_rs2;
              cache_signed <= pend_signed;
              cache_quot   <= corr_q;
              cache_rem    <= corr_r;
              state        <= ST_DONE;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The outstanding core op ends here; its result is discarded
          if (core_done) begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer with a behavioural core
module tb_div_sequencer;
  import div_pkg::*;

  localparam int TAG_W = 5;
  localparam int LAT   = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             core_start;
  logic [31:0]      core_dividend;
  logic [31:0]      core_divisor;
  logic             core_done;
  logic [31:0]      core_quotient;
  logic [31:0]      core_remainder;

  int compared   = 0;
  int mismatched = 0;

  div_sequencer #(.TAG_W(TAG_W), .CACHE_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_tag        (req_tag),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_tag       (resp_tag),
    .core_start     (core_start),
    .core_dividend  (core_dividend),
    .core_divisor   (core_divisor),
    .core_done      (core_done),
    .core_quotient  (core_quotient),
    .core_remainder (core_remainder)
  );

  always #5 clk = ~clk;

  // Behavioural divider core: done pulse LAT cycles after the start cycle
  logic        core_busy;
  int          core_cnt;
  logic [31:0] core_a;
  logic [31:0] core_b;
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (rst) begin
      core_busy      <= 1'b0;
      core_cnt       <= 0;
      core_quotient  <= 32'd0;
      core_remainder <= 32'd0;
    end else if (core_start) begin
      core_busy <= 1'b1;
      core_cnt  <= LAT - 2;
      core_a    <= core_dividend;
      core_b    <= core_divisor;
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        core_busy      <= 1'b0;
        core_done      <= 1'b1;
        core_quotient  <= (core_b == 0) ? 32'hFFFF_FFFF : core_a / core_b;
        core_remainder <= (core_b == 0) ? core_a : core_a % core_b;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one request; returns in the cycle after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    chk("req_ready_before_issue", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("resp_valid_within_budget", resp_valid, 1);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("req_ready_after_handshake", req_ready, 1);
    chk("resp_valid_after_handshake", resp_valid, 0);
  endtask

  initial begin
    int n;
    logic saw_bad_valid;
    logic saw_bad_ready;

    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_rs1    = 32'd0;
    req_rs2    = 32'd0;
    req_tag    = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    chk("reset_req_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_resp_tag", resp_tag, 32'd0);
    chk("reset_core_start", core_start, 0);
    chk("reset_core_dividend", core_dividend, 32'd0);
    chk("reset_core_divisor", core_divisor, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", req_ready, 1);

    // DIV -7 / 2 through the core
    issue(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
    chk("div_core_start", core_start, 1);
    chk("div_core_dividend", core_dividend, 32'd7);
    chk("div_core_divisor", core_divisor, 32'd2);
    wait_resp(n);
    chk("div_latency", n, LAT + 1);
    chk("div_data", resp_data, 32'hFFFF_FFFD);
    chk("div_tag", resp_tag, 32'd3);
    handshake();

    // REM -7 / 2 served from the cache
    issue(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4);
    chk("rem_hit_valid", resp_valid, 1);
    chk("rem_hit_no_start", core_start, 0);
    chk("rem_hit_data", resp_data, 32'hFFFF_FFFF);
    chk("rem_hit_tag", resp_tag, 32'd4);
    handshake();

    // Divide by zero
    issue(DIV_OP_DIVU, 32'd100, 32'd0, 5'd5);
    chk("divu0_valid", resp_valid, 1);
    chk("divu0_no_start", core_start, 0);
    chk("divu0_data", resp_data, 32'hFFFF_FFFF);
    handshake();
    issue(DIV_OP_REMU, 32'd100, 32'd0, 5'd6);
    chk("remu0_valid", resp_valid, 1);
    chk("remu0_data", resp_data, 32'd100);
    handshake();

    // Signed overflow
    issue(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1);
    chk("ovf_div_valid", resp_valid, 1);
    chk("ovf_div_no_start", core_start, 0);
    chk("ovf_div_data", resp_data, 32'h8000_0000);
    handshake();
    issue(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    chk("ovf_rem_valid", resp_valid, 1);
    chk("ovf_rem_data", resp_data, 32'd0);
    handshake();

    // Flush five cycles after core_start
    issue(DIV_OP_DIVU, 32'd50, 32'd7, 5'd7);
    chk("flush_op_core_start", core_start, 1);
    for (int i = 0; i < 5; i++) tick();
    flush     = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("flush_req_ready", req_ready, 0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    saw_bad_valid = 1'b0;
    saw_bad_ready = 1'b0;
    n = 0;
    while (!core_done && n < 50) begin
      if (resp_valid) saw_bad_valid = 1'b1;
      if (req_ready) saw_bad_ready = 1'b1;
      tick();
      n++;
    end
    chk("drain_core_done_seen", core_done, 1);
    chk("drain_no_resp_valid", saw_bad_valid, 0);
    chk("drain_no_req_ready", saw_bad_ready, 0);
    chk("drain_ready_at_done", req_ready, 0);
    tick();
    chk("drain_exit_ready", req_ready, 1);
    chk("drain_exit_resp_valid", resp_valid, 0);

    // Same op again misses and restarts the core
    issue(DIV_OP_DIVU, 32'd50, 32'd7, 5'd8);
    chk("reissue_core_start", core_start, 1);
    chk("reissue_dividend", core_dividend, 32'd50);
    wait_resp(n);
    chk("reissue_data", resp_data, 32'd7);
    chk("reissue_tag", resp_tag, 32'd8);

    // Back-pressure for ten cycles in DONE
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, 32'd7);
      chk("hold_tag", resp_tag, 32'd8);
      chk("hold_req_ready", req_ready, 0);
    end
    handshake();
    issue(DIV_OP_REMU, 32'd50, 32'd7, 5'd9);
    chk("remu_hit_valid", resp_valid, 1);
    chk("remu_hit_no_start", core_start, 0);
    chk("remu_hit_data", resp_data, 32'd1);
    chk("remu_hit_tag", resp_tag, 32'd9);
    handshake();

    // Reset while the core is running
    issue(DIV_OP_DIV, 32'd100, 32'hFFFF_FFFB, 5'd10);
    chk("rstrun_core_start", core_start, 1);
    chk("rstrun_divisor", core_divisor, 32'd5);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstrun_resp_valid", resp_valid, 0);
    chk("rstrun_resp_data", resp_data, 32'd0);
    chk("rstrun_resp_tag", resp_tag, 32'd0);
    chk("rstrun_core_start", core_start, 0);
    chk("rstrun_core_dividend", core_dividend, 32'd0);
    chk("rstrun_core_divisor", core_divisor, 32'd0);
    chk("rstrun_req_ready", req_ready, 1);

    issue(DIV_OP_DIVU, 32'd9, 32'd3, 5'd11);
    chk("post_rst_core_start", core_start, 1);
    chk("post_rst_dividend", core_dividend, 32'd9);
    wait_resp(n);
    chk("post_rst_data", resp_data, 32'd3);
    chk("post_rst_tag", resp_tag, 32'd11);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Controller between the execute stage and the iterative unsigned divider core for RV32M DIV/DIVU/REM/REMU. Accepts one operation at a time over a ready/valid request port. Resolves RISC-V special cases without using the core and converts signed operands to magnitudes. Sign-corrects the core result, and keeps a one-entry operand cache so a DIV/REM pair on the same operands completes without a second core run.

## Interface
- TAG_W, 5, width of destination-register tag carried with the request
- CACHE_EN, 1, 1 enables the one-entry result cache; 0 means every hit test is false
- clk  in  1  clock, single domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  cancel in-flight operation and invalidate cache (pipeline redirect)
- req_valid  in  1  operation offered
- req_ready  out  1  operation accepted when req_valid && req_ready
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- req_rs1  in  32  dividend
- req_rs2  in  32  divisor
- req_tag  in  TAG_W  destination tag
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  32  quotient or remainder per op
- resp_tag  out  TAG_W  tag of the completed op
- core_start  out  1  one-cycle start pulse to the divider core
- core_dividend  out  32  unsigned dividend magnitude
- core_divisor  out  32  unsigned divisor magnitude
- core_done  in  1  one-cycle pulse; core_quotient/core_remainder valid this cycle
- core_quotient  in  32  unsigned quotient
- core_remainder  in  32  unsigned remainder

## Operation
- States: IDLE, RUN, DRAIN, DONE. req_ready = (state==IDLE) && !flush && !rst.
- Signed op: op[0]==0. Magnitudes are taken as 2's-complement negation when signed and bit 31 is set; otherwise the raw value.
- Quotient sign: rs1[31]^rs2[31]. Remainder sign: rs1[31]. Sign is applied only for signed ops.
- IDLE, accept: one of the following applies.
  - Divisor 0: quotient 0xFFFFFFFF, remainder rs1. Go to DONE.
  - Signed op, rs1 0x80000000, rs2 0xFFFFFFFF: quotient 0x80000000, remainder 0. Go to DONE.
  - Cache hit (valid, rs1, rs2 and signedness equal): return the cached corrected value. Go to DONE.
  - Otherwise: latch op, tag and signs; pulse core_start with the magnitudes; go to RUN.
- RUN, core_done: sign-correct and select per op[1]. Write resp_data and fill the cache (rs1, rs2, signedness, corrected quotient and remainder). Go to DONE.
- DONE: hold resp_valid, resp_data and resp_tag stable until resp_ready; then go to IDLE.
- Special-case results are not cached.
- flush, any state:
  - Cache is invalidated.
  - DONE: drop the response, go to IDLE.
  - RUN: go to DRAIN. Stay there until core_done, discard the result and do not fill the cache, then go to IDLE.
  - DRAIN: stays in DRAIN.
  - flush and core_done in the same cycle in RUN: result discarded, go to IDLE.
  - flush with req_valid: flush wins, request not accepted.
- rst: state IDLE, cache invalid. Any in-flight core operation is abandoned; the core is reset on the same rst.

## Timing
- Reset values: resp_valid 0, resp_data 0, resp_tag 0, core_start 0, core_dividend 0, core_divisor 0, cache valid 0.
- Accept at cycle T, special case or cache hit: resp_valid at T+1.
- Accept at cycle T, core path: core_start high exactly at T+1. core_done arrives at T+1+L (core latency L, nominally 33). resp_valid follows at T+2+L.
- Handshake at cycle H: req_ready high at H+1, so the minimum request spacing is 2 cycles.
- core_start never asserts outside the IDLE→RUN transition; at most one core op is outstanding.
- All outputs except req_ready are registered.

## Structure
- Shared package div_pkg:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU
  - state enum
  - constants DIV_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000
- One sub-module, div_special_case (combinational): takes rs1, rs2 and signed; outputs is_special, special_q, special_r. This keeps the special-case table unit-testable.
- The divider core is instantiated by the parent, not inside this block.

## Test plan
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 → core sees 7/2; resp_data 0xFFFFFFFD (-3). Then REM on the same operands → cache hit, resp_data 0xFFFFFFFF (-1) one cycle after accept, no core_start.
- DIVU rs1=100, rs2=0 → resp_data 0xFFFFFFFF at T+1, no core_start. REMU 100/0 → resp_data 100.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Both at T+1, nothing cached.
- flush 5 cycles after core_start → req_ready stays 0 until core_done, no resp_valid. A repeat of the same op then misses the cache and restarts the core.
- resp_ready held low 10 cycles in DONE → resp_data and resp_tag stable, req_ready 0. Handshake, then a new request is accepted the following cycle.
- rst asserted during RUN → next cycle all outputs at reset values and req_ready 1 after rst deasserts. A subsequent DIVU 9/3 returns 3.
